// File: rtl/echo_indication_deserializer.sv
// Echo indication deserializer: packs three 32-bit portal words
// into one 96-bit message and hands it downstream.
//
// Ports:
//   CLK, RST        rising-edge clock, synchronous active-high reset
//   word_enq__ENA   upstream word strobe
//   word_enq_v      upstream word
//   word_enq__RDY   a word can be taken this cycle
//   pipe_enq__ENA   message delivered this cycle
//   pipe_enq_v      {heard v, heard meth, tag}
//   pipe_enq__RDY   downstream can take a message
//   msg_count       messages delivered (wraps at 16 bits)
//   word_idx        words held for the message in progress
module echo_indication_deserializer #(
    parameter int WORD_WIDTH = 32,
    parameter int MSG_WORDS  = 3
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            word_enq__ENA,
    input  logic [WORD_WIDTH-1:0]           word_enq_v,
    output logic                            word_enq__RDY,
    output logic                            pipe_enq__ENA,
    output logic [WORD_WIDTH*MSG_WORDS-1:0] pipe_enq_v,
    input  logic                            pipe_enq__RDY,
    output logic [15:0]                     msg_count,
    output logic [1:0]                      word_idx
);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_e;

    localparam logic [1:0] LAST_IDX = 2'(MSG_WORDS - 1);

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [15:0]           msg_count_q, msg_count_d;
    logic [WORD_WIDTH-1:0] slot_q [MSG_WORDS];
    logic [WORD_WIDTH-1:0] slot_d [MSG_WORDS];

    logic accept;
    logic deliver;

    // In FULL the slots are free again only once the message leaves,
    // so upstream readiness follows downstream readiness there.
    assign word_enq__RDY = (state_q == COLLECT) ? 1'b1 : pipe_enq__RDY;
    assign deliver       = (state_q == FULL) && pipe_enq__RDY;
    assign accept        = word_enq__ENA && word_enq__RDY;

    assign pipe_enq__ENA = deliver;
    assign msg_count     = msg_count_q;
    assign word_idx      = idx_q;

    always_comb begin
        for (int i = 0; i < MSG_WORDS; i++) begin
            pipe_enq_v[i*WORD_WIDTH +: WORD_WIDTH] = slot_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        msg_count_d = msg_count_q;
        slot_d      = slot_q;
        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    slot_d[idx_q] = word_enq_v;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 2'd0;
                        state_d = FULL;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            FULL: begin
                if (deliver) begin
                    state_d     = COLLECT;
                    msg_count_d = msg_count_q + 16'd1;
                    // A word taken on the delivery cycle opens the
                    // next message, sustaining one message per 3 cycles.
                    if (accept) begin
                        slot_d[0] = word_enq_v;
                        idx_d     = 2'd1;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= COLLECT;
            idx_q       <= 2'd0;
            msg_count_q <= 16'd0;
            for (int i = 0; i < MSG_WORDS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            msg_count_q <= msg_count_d;
            slot_q      <= slot_d;
        end
    end

endmodule
